// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, frame builder and top FSM state type for uart_tx_data3.
// UART_TX_PARITY_EN adds an even-parity bit to every frame (11-bit frames instead of 10).
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int NUM_BYTES = 5;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_BITS-1:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction
endpackage

// File: rtl/uart_tx_data3_if.sv
// uart_tx_data3_if: payload/start/done handshake and serial line of uart_tx_data3.
interface uart_tx_data3_if;
  logic [39:0] Data40;
  logic Trans_Go;
  logic Trans_Done;
  logic uart_tx;
  modport master (output Data40, Trans_Go, input Trans_Done, uart_tx);
  modport slave (input Data40, Trans_Go, output Trans_Done, uart_tx);
endinterface

// File: rtl/uart_tx_data3_byte_tx.sv
// uart_byte_tx: single-byte UART transmitter; frame shape comes from uart_pkg (UART_TX_PARITY_EN).
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200
) (
  input logic Clk,
  input logic Reset,
  input logic [7:0] Data,
  input logic Send_Go,
  output logic Tx_Done,
  output logic uart_tx
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int BW = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(BIT_CYC - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  logic [FRAME_BITS-1:0] sh;
  logic [BW-1:0] baud;
  logic [3:0] bit_cnt;
  logic busy, wrap;
  // The line is the LSB of the frame shifter; it refills with ones so it idles high.
  assign uart_tx = sh[0];
  assign wrap = busy && baud == BAUD_MAX;
  // Done is raised in the last stop-bit cycle so the next byte can load without a gap.
  assign Tx_Done = wrap && bit_cnt == LAST_BIT;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sh <= '1;
      baud <= '0;
      bit_cnt <= '0;
      busy <= 1'b0;
    end else if (Send_Go) begin
      sh <= make_frame(Data);
      baud <= '0;
      bit_cnt <= '0;
      busy <= 1'b1;
    end else if (wrap) begin
      sh <= {1'b1, sh[FRAME_BITS-1:1]};
      baud <= '0;
      bit_cnt <= bit_cnt + 4'd1;
      busy <= !Tx_Done;
    end else if (busy) begin
      baud <= baud + 1'b1;
    end
endmodule

// File: rtl/uart_tx_data3.sv
// uart_tx_data3: sends a latched 40-bit word as five back-to-back UART frames, LSB byte first.
// UART_TX_PARITY_EN selects 8E1-style frames with an even-parity bit.
module uart_tx_data3
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200
) (
  input logic Clk,
  input logic Reset,
  uart_tx_data3_if.slave bus
);
  state_t state, state_n;
  logic go_q, kick, go_edge, tx_done, send_go, last;
  logic [NUM_BYTES*DATA_BITS-1:0] data_q;
  logic [2:0] idx;
  assign go_edge = bus.Trans_Go & ~go_q;
  assign last = idx == 3'(NUM_BYTES - 1);
  // Byte 0 is kicked one cycle after the start edge; later bytes chain on the previous done.
  assign send_go = kick | (state == SEND && tx_done && !last);
  assign bus.Trans_Done = state == DONE;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (go_edge ? SEND : IDLE) :
              state == SEND ? ((tx_done && last) ? DONE : SEND) : IDLE;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      go_q <= 1'b0;
      kick <= 1'b0;
      data_q <= '0;
      idx <= '0;
    end else begin
      go_q <= bus.Trans_Go;
      kick <= state == IDLE && go_edge;
      if (state == IDLE && go_edge) begin
        data_q <= bus.Data40;
        idx <= '0;
      end else if (state == SEND && tx_done) begin
        data_q <= data_q >> DATA_BITS;
        idx <= idx + 3'd1;
      end
    end
  uart_byte_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_byte (
    .Clk(Clk),
    .Reset(Reset),
    .Data(kick ? data_q[7:0] : data_q[15:8]),
    .Send_Go(send_go),
    .Tx_Done(tx_done),
    .uart_tx(bus.uart_tx)
  );
endmodule

// File: tb/tb_uart_tx_data3.sv
// tb_uart_tx_data3: randomized bench for uart_tx_data3 against a bit-level line model.
module tb_uart_tx_data3;
  localparam int CLK_FREQ = 1_000_000, BAUD = 100_000, BC = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif
  localparam int N = 5 * FR * BC;
  logic Clk = 1'b0, Reset = 1'b1;
  uart_tx_data3_if bus();
  uart_tx_data3 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  int tests = 0, fails = 0;
  logic line_q[$];
  logic exp_q[$];
  int done_cnt, done_at;

  function automatic logic [39:0] rand40();
    logic [39:0] r;
    r = {8'($urandom), 32'($urandom)};
    return r;
  endfunction

  // Expected line, one entry per clock from the start bit, plus the idle cycle with done.
  task automatic build_wave(input logic [39:0] d);
    logic [7:0] b;
    logic bits[$];
    exp_q = {};
    for (int k = 0; k < 5; k++) begin
      b = d[8*k +: 8];
      bits = {1'b0};
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (FR == 11) bits.push_back(^b);
      bits.push_back(1'b1);
      foreach (bits[j]) for (int c = 0; c < BC; c++) exp_q.push_back(bits[j]);
    end
    exp_q.push_back(1'b1);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= line_q.size() || line_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic start(input logic [39:0] d);
    bus.Data40 = d;
    @(negedge Clk);
    bus.Trans_Go = 1'b1;
    @(negedge Clk);
  endtask

  task automatic capture(input int disturb);
    line_q = {};
    done_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge Clk);
      if (c <= N + 1) line_q.push_back(bus.uart_tx);
      if (bus.Trans_Done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (disturb > 0 && c == disturb) begin
        bus.Trans_Go = 1'b0;
        bus.Data40 = rand40();
      end
      if (disturb > 0 && c == disturb + 3) bus.Trans_Go = 1'b1;
    end
  endtask

  task automatic run_check(input string name, input logic [39:0] d, input int disturb);
    int bad;
    build_wave(d);
    start(d);
    tests++;
    if (bus.uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL %s start_latency: line %b at edge E, required 1", name, bus.uart_tx);
    end
    capture(disturb);
    bad = first_diff();
    tests++;
    if (bad !== -1) begin
      fails++;
      $display("FAIL %s line: cycle %0d got %b required %b (data %h)", name, bad + 1, line_q[bad], exp_q[bad], d);
    end
    tests++;
    if (done_cnt !== 1 || done_at !== N + 1) begin
      fails++;
      $display("FAIL %s done: %0d pulses first at cycle %0d, required 1 at %0d", name, done_cnt, done_at, N + 1);
    end
  endtask

  task automatic test_reset();
    int bad_tx = 0, bad_done = 0;
    bus.Trans_Go = 1'b0;
    bus.Data40 = '0;
    Reset = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      if (bus.uart_tx !== 1'b1) bad_tx++;
      if (bus.Trans_Done !== 1'b0) bad_done++;
    end
    tests += 2;
    if (bad_tx !== 0) begin fails++; $display("FAIL reset_tx: %0d non-idle samples, required 0", bad_tx); end
    if (bad_done !== 0) begin fails++; $display("FAIL reset_done: %0d done samples, required 0", bad_done); end
    Reset = 1'b0;
    bad_tx = 0;
    repeat (30) begin
      @(negedge Clk);
      if (bus.uart_tx !== 1'b1 || bus.Trans_Done !== 1'b0) bad_tx++;
    end
    tests++;
    if (bad_tx !== 0) begin fails++; $display("FAIL idle_after_reset: %0d bad samples, required 0", bad_tx); end
  endtask

  task automatic test_basic();
    int pi;
    run_check("basic", 40'h123456789a, 0);
    if (FR == 11) begin
      pi = 9 * BC + BC / 2;
      tests++;
      if (line_q[pi] !== ^exp_parity_byte()) begin
        fails++;
        $display("FAIL parity_bit: got %b required %b", line_q[pi], ^exp_parity_byte());
      end
    end
  endtask

  function automatic logic [7:0] exp_parity_byte();
    logic [39:0] d;
    d = 40'h123456789a;
    return d[7:0];
  endfunction

  task automatic test_hold_no_retrigger();
    int bad = 0;
    repeat (2 * FR * BC) begin
      @(negedge Clk);
      if (bus.uart_tx !== 1'b1 || bus.Trans_Done !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL hold_retrigger: %0d active samples, required 0", bad); end
    bus.Trans_Go = 1'b0;
    repeat (5) @(negedge Clk);
    run_check("second", 40'ha987654321, 0);
  endtask

  task automatic test_mid_change();
    bus.Trans_Go = 1'b0;
    repeat (3) @(negedge Clk);
    run_check("mid_change", rand40(), N / 2);
  endtask

  task automatic test_reset_mid();
    logic [39:0] d;
    int at, bad = 0, dn = 0;
    bus.Trans_Go = 1'b0;
    repeat (3) @(negedge Clk);
    d = rand40();
    build_wave(d);
    start(d);
    at = 2 * FR * BC + 3;
    repeat (at) @(negedge Clk);
    tests++;
    if (bus.uart_tx !== exp_q[at - 1]) begin
      fails++;
      $display("FAIL pre_reset_line: got %b required %b", bus.uart_tx, exp_q[at - 1]);
    end
    #2 Reset = 1'b1;
    #1;
    tests++;
    if (bus.uart_tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx: got %b required 1", bus.uart_tx); end
    for (int c = 0; c < N; c++) begin
      @(negedge Clk);
      if (c == 5) begin Reset = 1'b0; bus.Trans_Go = 1'b0; end
      if (bus.Trans_Done !== 1'b0) dn++;
      if (bus.uart_tx !== 1'b1) bad++;
    end
    tests += 2;
    if (dn !== 0) begin fails++; $display("FAIL reset_mid_done: %0d pulses, required 0", dn); end
    if (bad !== 0) begin fails++; $display("FAIL reset_mid_line: %0d active samples, required 0", bad); end
    run_check("after_reset", rand40(), 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      bus.Trans_Go = 1'b0;
      repeat (1 + $urandom_range(3, 0)) @(negedge Clk);
      run_check("random", rand40(), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_no_retrigger();
    test_mid_change();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
